// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
//   Single-cycle codes (add/sub/and/or/slt) register their result on the
//   accept edge. Shift codes (sll/srl/sra) with a non-zero amount are
//   iterated one bit per cycle in a SHIFT state.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (alu_ctrl, src_a, src_b)
//   alu_ctrl            000 add, 001 sub, 010 and, 011 or, 101 slt,
//                       100 sll, 110 srl, 111 sra
//   src_a, src_b        operands; shift amount is src_b[SHW-1:0]
//   out_valid/out_ready result handshake
//   result, zero        registered result and (result == 0)
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [1:0]       sop_q, sop_d;     // alu_ctrl[1:0] of the running shift
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             out_valid_q, out_valid_d;

   logic             accept;
   logic             is_shift;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_val;
   logic [WIDTH-1:0] work_sh;

   // in_ready must not look at in_valid; only out_ready is a live input here.
   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign is_shift  = alu_ctrl[2] && (alu_ctrl != 3'b101);
   assign shamt     = src_b[SHW-1:0];

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;

   // One-cycle result; shift codes land here only with shamt == 0,
   // where the answer is src_a unchanged.
   always_comb begin
      alu_val = src_a;
      case (alu_ctrl)
         3'b000:  alu_val = src_a + src_b;
         3'b001:  alu_val = src_a - src_b;
         3'b010:  alu_val = src_a & src_b;
         3'b011:  alu_val = src_a | src_b;
         3'b101:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: alu_val = src_a;
      endcase
   end

   // One bit position per SHIFT cycle.
   always_comb begin
      work_sh = work_q << 1;
      case (sop_q)
         2'b10:   work_sh = work_q >> 1;
         2'b11:   work_sh = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         default: work_sh = work_q << 1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      sop_d       = sop_q;
      result_d    = result_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_shift && (shamt != '0)) begin
                  state_d = SHIFT;
                  work_d  = src_a;
                  cnt_d   = shamt;
                  sop_d   = alu_ctrl[1:0];
               end else begin
                  result_d    = alu_val;
                  zero_d      = (alu_val == '0);
                  out_valid_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            work_d = work_sh;
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               result_d    = work_sh;
               zero_d      = (work_sh == '0);
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         sop_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         sop_q       <= sop_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A scoreboard queue
// holds the expected result of every accepted operation and is checked at
// each output handshake; the scenario tasks add timing/handshake checks.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  alu_ctrl;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] sb_q[$];

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (c)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b100:  return a << sh;
         3'b110:  return a >> sh;
         default: return $unsigned($signed(a) >>> sh);
      endcase
   endfunction

   // Scoreboard: every output handshake pops one expected value.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         logic [31:0] exp_r;
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: result %h with nothing expected", result);
         end else begin
            exp_r = sb_q.pop_front();
            if (result !== exp_r || zero !== (exp_r == 32'd0)) begin
               n_err++;
               $display("FAIL sb_result: got %h zero %b, want %h zero %b",
                        result, zero, exp_r, (exp_r == 32'd0));
            end
         end
      end
   end

   // Offer one op; returns after the accept edge (+1). waited = stall cycles.
   task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, output int waited);
      alu_ctrl = c; src_a = a; src_b = b; in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) begin
         n_err++;
         $display("FAIL send_timeout: in_ready stayed %b, want 1", in_ready);
      end else begin
         sb_q.push_back(model(c, a, b));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      alu_ctrl = '0; src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: ov %b res %h zero %b rdy %b, want 0 0 1 1",
                  out_valid, result, zero, in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int w, tot;
      tot = 0;
      out_ready = 1'b1;
      send(3'b000, 32'd5, 32'd7, w);             tot += w;
      send(3'b001, 32'd3, 32'd5, w);             tot += w;
      send(3'b010, 32'hF0F0, 32'h0FF0, w);       tot += w;
      send(3'b011, 32'hF000, 32'h000F, w);       tot += w;
      send(3'b001, 32'd9, 32'd9, w);             tot += w;
      n_vec++;
      if (tot !== 0) begin
         n_err++;
         $display("FAIL b2b_throughput: %0d stall cycles, want 0", tot);
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_sub_zero: ov %b res %h zero %b, want 1 0 1", out_valid, result, zero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_slt;
      int w;
      out_ready = 1'b1;
      send(3'b101, 32'hFFFFFFFF, 32'd1, w);
      send(3'b101, 32'd1, 32'hFFFFFFFF, w);
      send(3'b101, 32'h80000000, 32'h7FFFFFFF, w);
      send(3'b101, 32'h1234, 32'h1234, w);
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_shift;
      logic [2:0]  c_t[5] = '{3'b100, 3'b110, 3'b111, 3'b100, 3'b110};
      logic [31:0] a_t[5] = '{32'h1, 32'h80000000, 32'h80000000, 32'hDEADBEEF, 32'hFF};
      logic [31:0] b_t[5] = '{32'd5, 32'd31, 32'd4, 32'h20, 32'h104};
      int          l_t[5] = '{6, 32, 5, 1, 5};
      int w, n, low;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(c_t[i], a_t[i], b_t[i], w);
         n = 1; low = 0;
         @(negedge clk);
         while (!out_valid && n < 100) begin
            if (in_ready !== 1'b0) low = -1000;
            else low++;
            @(negedge clk);
            n++;
         end
         n_vec++;
         if (n !== l_t[i] || low !== l_t[i] - 1) begin
            n_err++;
            $display("FAIL shift_latency[%0d]: latency %0d busy %0d, want %0d busy %0d",
                     i, n, low, l_t[i], l_t[i] - 1);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      int w;
      out_ready = 1'b0;
      send(3'b000, 32'd2, 32'd3, w);
      alu_ctrl = 3'b000; src_a = 32'd10; src_b = 32'd20; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b1 || result !== 32'd5 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: ov %b res %h rdy %b, want 1 5 0",
                     i, out_valid, result, in_ready);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_ready: in_ready %b, want 1", in_ready);
      end else begin
         sb_q.push_back(32'd30);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'd30) begin
         n_err++;
         $display("FAIL bp_handoff: ov %b res %h, want 1 0000001e", out_valid, result);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_shift;
      int w;
      out_ready = 1'b1;
      send(3'b100, 32'h1, 32'd10, w);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb_q.pop_back());
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_shift: ov %b res %h zero %b rdy %b, want 0 0 1 1",
                  out_valid, result, zero, in_ready);
      end
      @(posedge clk); #1;
      send(3'b000, 32'd1, 32'd1, w);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'd2) begin
         n_err++;
         $display("FAIL rst_then_add: ov %b res %h, want 1 00000002", out_valid, result);
      end
      repeat (3) @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_slt();
      test_shift();
      test_backpressure();
      test_reset_mid_shift();
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (sb_q.size() !== 0) begin
         n_err++;
         $display("FAIL sb_drain: %0d results never produced, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
